// File: rtl/rtc_hms_alarm.sv
// BCD hh:mm:ss time-of-day counter with a tick prescaler, validated time load
// and a one-shot sticky alarm that matches hh:mm:00 on a second advance.
module rtc_hms_alarm #(
    parameter int unsigned TICKS_PER_SEC = 1,
    parameter bit          MODE_24H      = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick_en,
    input  logic       load,
    input  logic [2:0] load_hr_tens,
    input  logic [3:0] load_hr_units,
    input  logic [2:0] load_min_tens,
    input  logic [3:0] load_min_units,
    input  logic [2:0] load_sec_tens,
    input  logic [3:0] load_sec_units,
    input  logic       load_pm,
    input  logic       alarm_we,
    input  logic [2:0] alarm_hr_tens,
    input  logic [3:0] alarm_hr_units,
    input  logic [2:0] alarm_min_tens,
    input  logic [3:0] alarm_min_units,
    input  logic       alarm_pm,
    input  logic       alarm_en,
    input  logic       alarm_clr,
    output logic [2:0] hr_tens,
    output logic [3:0] hr_units,
    output logic [2:0] min_tens,
    output logic [3:0] min_units,
    output logic [2:0] sec_tens,
    output logic [3:0] sec_units,
    output logic       pm,
    output logic       alarm,
    output logic       load_err
);

    localparam int          PW     = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [PW-1:0] PS_MAX = PW'(TICKS_PER_SEC - 1);
    // 12-hour mode comes out of reset at 12:00 AM rather than 00:00
    localparam logic [2:0]  RST_HT = MODE_24H ? 3'd0 : 3'd1;
    localparam logic [3:0]  RST_HU = MODE_24H ? 4'd0 : 4'd2;

    function automatic logic hr_ok(input logic [2:0] t, input logic [3:0] u);
        logic ok;
        if (u > 4'd9)
            ok = 1'b0;
        else if (MODE_24H)
            ok = (t < 3'd2) || (t == 3'd2 && u <= 4'd3);
        else
            ok = (t == 3'd0 && u != 4'd0) || (t == 3'd1 && u <= 4'd2);
        return ok;
    endfunction

    function automatic logic ms_ok(input logic [2:0] t, input logic [3:0] u);
        return (t <= 3'd5) && (u <= 4'd9);
    endfunction

    logic [PW-1:0] ps_q, ps_d;
    logic [2:0]    hr_tens_q, hr_tens_d, min_tens_q, min_tens_d, sec_tens_q, sec_tens_d;
    logic [3:0]    hr_units_q, hr_units_d, min_units_q, min_units_d, sec_units_q, sec_units_d;
    logic          pm_q, pm_d;
    logic [2:0]    al_ht_q, al_ht_d, al_mt_q, al_mt_d;
    logic [3:0]    al_hu_q, al_hu_d, al_mu_q, al_mu_d;
    logic          al_pm_q, al_pm_d;
    logic          alarm_q, alarm_d;
    logic          load_err_q, load_err_d;

    logic [2:0] nht, nmt, nst;
    logic [3:0] nhu, nmu, nsu;
    logic       npm;
    logic       tick_adv, sec_adv, load_ok, alarm_ok, alarm_hit;

    always_comb begin
        // next time after one second, always derived from the current time
        nht = hr_tens_q;  nhu = hr_units_q;
        nmt = min_tens_q; nmu = min_units_q;
        nst = sec_tens_q; nsu = sec_units_q;
        npm = pm_q;
        if (sec_units_q != 4'd9) begin
            nsu = sec_units_q + 4'd1;
        end else begin
            nsu = 4'd0;
            if (sec_tens_q != 3'd5) begin
                nst = sec_tens_q + 3'd1;
            end else begin
                nst = 3'd0;
                if (min_units_q != 4'd9) begin
                    nmu = min_units_q + 4'd1;
                end else begin
                    nmu = 4'd0;
                    if (min_tens_q != 3'd5) begin
                        nmt = min_tens_q + 3'd1;
                    end else begin
                        nmt = 3'd0;
                        if (MODE_24H) begin
                            if (hr_tens_q == 3'd2 && hr_units_q == 4'd3) begin
                                nht = 3'd0; nhu = 4'd0;
                            end else if (hr_units_q == 4'd9) begin
                                nht = hr_tens_q + 3'd1; nhu = 4'd0;
                            end else begin
                                nhu = hr_units_q + 4'd1;
                            end
                        end else begin
                            // 12 -> 01 keeps the meridiem; 11 -> 12 flips it
                            if (hr_tens_q == 3'd1 && hr_units_q == 4'd2) begin
                                nht = 3'd0; nhu = 4'd1;
                            end else if (hr_tens_q == 3'd1 && hr_units_q == 4'd1) begin
                                nhu = 4'd2; npm = ~pm_q;
                            end else if (hr_units_q == 4'd9) begin
                                nht = 3'd1; nhu = 4'd0;
                            end else begin
                                nhu = hr_units_q + 4'd1;
                            end
                        end
                    end
                end
            end
        end
    end

    always_comb begin
        ps_d        = ps_q;
        hr_tens_d   = hr_tens_q;  hr_units_d  = hr_units_q;
        min_tens_d  = min_tens_q; min_units_d = min_units_q;
        sec_tens_d  = sec_tens_q; sec_units_d = sec_units_q;
        pm_d        = pm_q;
        al_ht_d     = al_ht_q; al_hu_d = al_hu_q;
        al_mt_d     = al_mt_q; al_mu_d = al_mu_q;
        al_pm_d     = al_pm_q;

        // any load strobe swallows the same-cycle tick, accepted or not
        tick_adv = tick_en && !load;
        sec_adv  = tick_adv && (ps_q == PS_MAX);
        load_ok  = hr_ok(load_hr_tens, load_hr_units) &&
                   ms_ok(load_min_tens, load_min_units) &&
                   ms_ok(load_sec_tens, load_sec_units);
        alarm_ok = hr_ok(alarm_hr_tens, alarm_hr_units) &&
                   ms_ok(alarm_min_tens, alarm_min_units);

        if (tick_adv)
            ps_d = (ps_q == PS_MAX) ? '0 : ps_q + PW'(1);

        if (load) begin
            if (load_ok) begin
                hr_tens_d   = load_hr_tens;   hr_units_d  = load_hr_units;
                min_tens_d  = load_min_tens;  min_units_d = load_min_units;
                sec_tens_d  = load_sec_tens;  sec_units_d = load_sec_units;
                pm_d        = MODE_24H ? 1'b0 : load_pm;
                ps_d        = '0;
            end
        end else if (sec_adv) begin
            hr_tens_d  = nht; hr_units_d  = nhu;
            min_tens_d = nmt; min_units_d = nmu;
            sec_tens_d = nst; sec_units_d = nsu;
            pm_d       = MODE_24H ? 1'b0 : npm;
        end

        if (alarm_we && alarm_ok) begin
            al_ht_d = alarm_hr_tens;  al_hu_d = alarm_hr_units;
            al_mt_d = alarm_min_tens; al_mu_d = alarm_min_units;
            al_pm_d = MODE_24H ? 1'b0 : alarm_pm;
        end

        alarm_hit = sec_adv && alarm_en && nst == 3'd0 && nsu == 4'd0 &&
                    nht == al_ht_q && nhu == al_hu_q &&
                    nmt == al_mt_q && nmu == al_mu_q &&
                    (MODE_24H || npm == al_pm_q);
        alarm_d    = alarm_hit ? 1'b1 : (alarm_clr ? 1'b0 : alarm_q);
        load_err_d = (load && !load_ok) || (alarm_we && !alarm_ok);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ps_q        <= '0;
            hr_tens_q   <= RST_HT; hr_units_q  <= RST_HU;
            min_tens_q  <= 3'd0;   min_units_q <= 4'd0;
            sec_tens_q  <= 3'd0;   sec_units_q <= 4'd0;
            pm_q        <= 1'b0;
            al_ht_q     <= RST_HT; al_hu_q <= RST_HU;
            al_mt_q     <= 3'd0;   al_mu_q <= 4'd0;
            al_pm_q     <= 1'b0;
            alarm_q     <= 1'b0;
            load_err_q  <= 1'b0;
        end else begin
            ps_q        <= ps_d;
            hr_tens_q   <= hr_tens_d;  hr_units_q  <= hr_units_d;
            min_tens_q  <= min_tens_d; min_units_q <= min_units_d;
            sec_tens_q  <= sec_tens_d; sec_units_q <= sec_units_d;
            pm_q        <= pm_d;
            al_ht_q     <= al_ht_d; al_hu_q <= al_hu_d;
            al_mt_q     <= al_mt_d; al_mu_q <= al_mu_d;
            al_pm_q     <= al_pm_d;
            alarm_q     <= alarm_d;
            load_err_q  <= load_err_d;
        end
    end

    assign hr_tens   = hr_tens_q;
    assign hr_units  = hr_units_q;
    assign min_tens  = min_tens_q;
    assign min_units = min_units_q;
    assign sec_tens  = sec_tens_q;
    assign sec_units = sec_units_q;
    assign pm        = pm_q;
    assign alarm     = alarm_q;
    assign load_err  = load_err_q;

endmodule

// File: tb/tb_rtc_hms_alarm.sv
// Directed bench for rtc_hms_alarm: three instances (24h, 12h, 4 ticks/sec)
// checked against a queue of expected output words.
module tb_rtc_hms_alarm;

    typedef struct packed {
        logic       tick_en, load;
        logic [2:0] lht; logic [3:0] lhu;
        logic [2:0] lmt; logic [3:0] lmu;
        logic [2:0] lst; logic [3:0] lsu;
        logic       lpm, awe;
        logic [2:0] aht; logic [3:0] ahu;
        logic [2:0] amt; logic [3:0] amu;
        logic       apm, aen, aclr;
    } in_t;

    typedef struct {
        int          d;
        string       tag;
        logic [23:0] v;
    } exp_t;

    logic        clk;
    logic        reset;
    in_t         in_s [3];
    logic [23:0] obs  [3];
    exp_t        sb[$];
    int          checks;
    int          errors;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    for (genvar g = 0; g < 3; g++) begin : g_dut
        logic [2:0] hr_tens, min_tens, sec_tens;
        logic [3:0] hr_units, min_units, sec_units;
        logic       pm, alarm, load_err;
        rtc_hms_alarm #(
            .TICKS_PER_SEC((g == 2) ? 4 : 1),
            .MODE_24H     ((g == 1) ? 1'b0 : 1'b1)
        ) u_dut (
            .clk(clk), .reset(reset), .tick_en(in_s[g].tick_en), .load(in_s[g].load),
            .load_hr_tens(in_s[g].lht), .load_hr_units(in_s[g].lhu),
            .load_min_tens(in_s[g].lmt), .load_min_units(in_s[g].lmu),
            .load_sec_tens(in_s[g].lst), .load_sec_units(in_s[g].lsu),
            .load_pm(in_s[g].lpm), .alarm_we(in_s[g].awe),
            .alarm_hr_tens(in_s[g].aht), .alarm_hr_units(in_s[g].ahu),
            .alarm_min_tens(in_s[g].amt), .alarm_min_units(in_s[g].amu),
            .alarm_pm(in_s[g].apm), .alarm_en(in_s[g].aen), .alarm_clr(in_s[g].aclr),
            .hr_tens(hr_tens), .hr_units(hr_units), .min_tens(min_tens),
            .min_units(min_units), .sec_tens(sec_tens), .sec_units(sec_units),
            .pm(pm), .alarm(alarm), .load_err(load_err)
        );
        assign obs[g] = {hr_tens, hr_units, min_tens, min_units, sec_tens, sec_units,
                         pm, alarm, load_err};
    end

    function automatic logic [23:0] ev(input int h, input int m, input int s,
                                       input bit p, input bit al, input bit le);
        return {3'(h / 10), 4'(h % 10), 3'(m / 10), 4'(m % 10), 3'(s / 10), 4'(s % 10),
                p, al, le};
    endfunction

    function automatic logic [23:0] ev_s(input int secs, input bit al, input bit le);
        return ev(secs / 3600, (secs / 60) % 60, secs % 60, 1'b0, al, le);
    endfunction

    task automatic push(input int d, input string tag, input logic [23:0] v);
        exp_t x;
        x.d = d; x.tag = tag; x.v = v;
        sb.push_back(x);
    endtask

    task automatic check_all();
        exp_t x;
        while (sb.size() != 0) begin
            x = sb.pop_front();
            checks++;
            assert (obs[x.d] === x.v) else begin
                errors++;
                $error("FAIL %s dut%0d got %h want %h", x.tag, x.d, obs[x.d], x.v);
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        check_all();
        for (int i = 0; i < 3; i++) begin
            in_s[i].load = 1'b0; in_s[i].awe = 1'b0; in_s[i].aclr = 1'b0;
        end
    endtask

    task automatic drv_load(input int d, input int h, input int m, input int s, input bit p);
        in_s[d].load = 1'b1;
        in_s[d].lht = 3'(h / 10); in_s[d].lhu = 4'(h % 10);
        in_s[d].lmt = 3'(m / 10); in_s[d].lmu = 4'(m % 10);
        in_s[d].lst = 3'(s / 10); in_s[d].lsu = 4'(s % 10);
        in_s[d].lpm = p;
    endtask

    task automatic drv_alarm(input int d, input int h, input int m, input bit p);
        in_s[d].awe = 1'b1;
        in_s[d].aht = 3'(h / 10); in_s[d].ahu = 4'(h % 10);
        in_s[d].amt = 3'(m / 10); in_s[d].amu = 4'(m % 10);
        in_s[d].apm = p;
    endtask

    initial begin
        int tc;
        int sec;
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        for (int i = 0; i < 3; i++) in_s[i] = '0;
        #12;
        push(0, "rst24", ev(0, 0, 0, 0, 0, 0));
        push(1, "rst12", ev(12, 0, 0, 0, 0, 0));
        push(2, "rst4", ev(0, 0, 0, 0, 0, 0));
        check_all();
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // full day on the 24h instance
        in_s[0].tick_en = 1'b1;
        for (int i = 1; i <= 86400; i++) begin
            push(0, "day", ev_s(i % 86400, 0, 0));
            step();
        end
        in_s[0].tick_en = 1'b0;

        // 12h rollovers
        drv_load(1, 11, 59, 59, 1'b0); push(1, "h12_ld_am", ev(11, 59, 59, 0, 0, 0)); step();
        in_s[1].tick_en = 1'b1;        push(1, "h12_11am", ev(12, 0, 0, 1, 0, 0)); step();
        in_s[1].tick_en = 1'b0;
        drv_load(1, 12, 59, 59, 1'b1); push(1, "h12_ld_pm", ev(12, 59, 59, 1, 0, 0)); step();
        in_s[1].tick_en = 1'b1;        push(1, "h12_12pm", ev(1, 0, 0, 1, 0, 0)); step();
        in_s[1].tick_en = 1'b0;
        drv_load(1, 11, 59, 59, 1'b1); push(1, "h12_ld_pm2", ev(11, 59, 59, 1, 0, 0)); step();
        in_s[1].tick_en = 1'b1;        push(1, "h12_11pm", ev(12, 0, 0, 0, 0, 0)); step();
        in_s[1].tick_en = 1'b0;

        // rejected loads
        drv_load(0, 24, 0, 0, 1'b0); push(0, "bad_24h", ev(0, 0, 0, 0, 0, 1)); step();
        push(0, "bad_24h_end", ev(0, 0, 0, 0, 0, 0)); step();
        drv_load(1, 0, 30, 0, 1'b0); push(1, "bad_12h", ev(12, 0, 0, 0, 0, 1)); step();
        push(1, "bad_12h_end", ev(12, 0, 0, 0, 0, 0)); step();
        drv_load(0, 12, 34, 60, 1'b0); push(0, "bad_sec", ev(0, 0, 0, 0, 0, 1)); step();
        push(0, "bad_sec_end", ev(0, 0, 0, 0, 0, 0)); step();

        // load wins over a same-cycle tick
        in_s[0].tick_en = 1'b1;
        drv_load(0, 5, 6, 7, 1'b0); push(0, "ld_tick", ev(5, 6, 7, 0, 0, 0)); step();
        push(0, "ld_tick_nxt", ev(5, 6, 8, 0, 0, 0)); step();
        in_s[0].tick_en = 1'b0;

        // prescaler: 4 ticks per second, tick_en every other cycle
        tc = 0; sec = 0;
        for (int k = 0; k < 36; k++) begin
            in_s[2].tick_en = (k % 2 == 0);
            if (k % 2 == 0) begin
                tc++;
                if (tc == 4) begin tc = 0; sec++; end
            end
            push(2, "tps4", ev_s(sec, 0, 0));
            step();
        end
        in_s[2].tick_en = 1'b0;
        drv_load(2, 0, 10, 0, 1'b0); push(2, "tps4_load", ev(0, 10, 0, 0, 0, 0)); step();
        tc = 0; sec = 600;
        for (int k = 0; k < 8; k++) begin
            in_s[2].tick_en = (k % 2 == 0);
            if (k % 2 == 0) begin
                tc++;
                if (tc == 4) begin tc = 0; sec++; end
            end
            push(2, "tps4_restart", ev_s(sec, 0, 0));
            step();
        end
        in_s[2].tick_en = 1'b0;

        // alarm 07:30 on the 24h instance
        in_s[0].aen = 1'b1;
        drv_alarm(0, 7, 30, 1'b0);
        drv_load(0, 7, 29, 58, 1'b0); push(0, "al_setup", ev(7, 29, 58, 0, 0, 0)); step();
        in_s[0].tick_en = 1'b1;
        push(0, "al_pre", ev(7, 29, 59, 0, 0, 0)); step();
        push(0, "al_hit", ev(7, 30, 0, 0, 1, 0)); step();
        push(0, "al_sticky", ev(7, 30, 1, 0, 1, 0)); step();
        in_s[0].tick_en = 1'b0;
        in_s[0].aclr = 1'b1; push(0, "al_clr", ev(7, 30, 1, 0, 0, 0)); step();
        drv_alarm(0, 25, 0, 1'b0); push(0, "al_bad_we", ev(7, 30, 1, 0, 0, 1)); step();
        push(0, "al_bad_we_end", ev(7, 30, 1, 0, 0, 0)); step();
        drv_load(0, 7, 29, 59, 1'b0); push(0, "al_setup2", ev(7, 29, 59, 0, 0, 0)); step();
        in_s[0].tick_en = 1'b1; in_s[0].aclr = 1'b1;
        push(0, "al_set_beats_clr", ev(7, 30, 0, 0, 1, 0)); step();
        in_s[0].tick_en = 1'b0; in_s[0].aclr = 1'b1;
        push(0, "al_clr2", ev(7, 30, 0, 0, 0, 0)); step();
        drv_load(0, 7, 30, 0, 1'b0); push(0, "al_load_nohit", ev(7, 30, 0, 0, 0, 0)); step();
        in_s[0].aen = 1'b0;
        drv_load(0, 7, 29, 59, 1'b0); push(0, "al_dis_setup", ev(7, 29, 59, 0, 0, 0)); step();
        in_s[0].tick_en = 1'b1; push(0, "al_disabled", ev(7, 30, 0, 0, 0, 0)); step();
        in_s[0].tick_en = 1'b0;

        // 12h alarm needs meridiem to match
        in_s[1].aen = 1'b1;
        drv_alarm(1, 1, 0, 1'b1);
        drv_load(1, 12, 59, 59, 1'b0); push(1, "al12_setup", ev(12, 59, 59, 0, 0, 0)); step();
        in_s[1].tick_en = 1'b1; push(1, "al12_am_nohit", ev(1, 0, 0, 0, 0, 0)); step();
        in_s[1].tick_en = 1'b0;
        drv_load(1, 12, 59, 59, 1'b1); push(1, "al12_setup_pm", ev(12, 59, 59, 1, 0, 0)); step();
        in_s[1].tick_en = 1'b1; push(1, "al12_pm_hit", ev(1, 0, 0, 1, 1, 0)); step();
        in_s[1].tick_en = 1'b0;

        // asynchronous reset mid-minute
        drv_load(0, 0, 12, 30, 1'b0); push(0, "mid_ld", ev(0, 12, 30, 0, 0, 0)); step();
        in_s[0].tick_en = 1'b1;
        push(0, "mid_run1", ev(0, 12, 31, 0, 0, 0)); step();
        push(0, "mid_run2", ev(0, 12, 32, 0, 0, 0)); step();
        #2;
        reset = 1'b1;
        #1;
        push(0, "async_rst24", ev(0, 0, 0, 0, 0, 0));
        push(1, "async_rst12", ev(12, 0, 0, 0, 0, 0));
        push(2, "async_rst4", ev(0, 0, 0, 0, 0, 0));
        check_all();
        #2;
        reset = 1'b0;
        in_s[0].tick_en = 1'b0;
        @(posedge clk);
        #1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
